divider_n_core: RTL

- Parametrised sequential shift-subtract (restoring) divider. It replaces the software division loop that the divider top currently runs on the PicoBlaze.
- Same Start/Ack handshake and one-hot Qi/Qc/Qd state outputs as the existing divider top, so it drops into the switch/LED/SSD top-level without rework.
- Produces one quotient bit per clock.
- Adds three things the current design lacks: arbitrary WIDTH, a divide-by-zero flag, and an optional signed mode.

---
 rtl/divider_n_core.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/divider_n_core.sv
// divider_n_core: sequential restoring shift-subtract divider.
// It produces one quotient bit per clock and uses a Start/Ack handshake
// with one-hot state flags (Qi/Qc/Qd).
//
// Optional feature: define DIVIDER_N_SIGNED_EN for two's-complement operands.
// Operands are captured as magnitudes, the unsigned core runs unchanged, and
// the signs are applied when the result is loaded.
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    synchronous active-low reset
//   Start      begins a division (sampled in QI only)
//   Ack        returns the block to QI (sampled in QD only)
//   Xin, Yin   dividend / divisor, captured on the QI->QC edge
//   Quotient   registered result, valid while Done=1
//   Remainder  registered result, valid while Done=1
//   DivByZero  registered, set when the captured divisor was 0
//   Done       equals Qd
//   Qi/Qc/Qd   one-hot state flags
module divider_n_core #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Ack,
  input  logic [WIDTH-1:0] Xin,
  input  logic [WIDTH-1:0] Yin,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Done,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    QI = 3'b001,
    QC = 3'b010,
    QD = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] x, y, r;
  // Only WIDTH-1 quotient bits are stored. The final bit goes straight
  // into the Quotient output register.
  logic [WIDTH-2:0] q;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   t;
  logic             ge, last, y_zero;
  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic [WIDTH-1:0] x_cap, y_cap, q_load, r_load, rz_load;

  // Compare and subtract at WIDTH+1 bits so no operand pair can overflow.
  // Because T-Y < Y, the low WIDTH bits of the difference hold the result.
  always_comb begin
    t      = {r, x[WIDTH-1]};
    ge     = (t >= {1'b0, y});
    r_nxt  = ge ? (t[WIDTH-1:0] - y) : t[WIDTH-1:0];
    q_nxt  = {q, ge};
    y_zero = (y == '0);
    last   = (count == CNT_W'(WIDTH - 1));
  end

`ifdef DIVIDER_N_SIGNED_EN
  logic sq, sr;

  always_comb begin
    x_cap   = Xin[WIDTH-1] ? -Xin : Xin;
    y_cap   = Yin[WIDTH-1] ? -Yin : Yin;
    q_load  = sq ? -q_nxt : q_nxt;
    r_load  = sr ? -r_nxt : r_nxt;
    // Re-negating the dividend magnitude gives back the original Xin,
    // including the most-negative value.
    rz_load = sr ? -x : x;
  end
`else
  always_comb begin
    x_cap   = Xin;
    y_cap   = Yin;
    q_load  = q_nxt;
    r_load  = r_nxt;
    rz_load = x;
  end
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= QI;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      QI:      if (Start)           state_nxt = QC;
      QC:      if (y_zero || last)  state_nxt = QD;
      QD:      if (Ack)             state_nxt = QI;
      default:                      state_nxt = QI;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x         <= '0;
      y         <= '0;
      r         <= '0;
      q         <= '0;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
`ifdef DIVIDER_N_SIGNED_EN
      sq        <= 1'b0;
      sr        <= 1'b0;
`endif
    end else begin
      case (state)
        QI: begin
          if (Start) begin
            x     <= x_cap;
            y     <= y_cap;
            r     <= '0;
            q     <= '0;
            count <= '0;
`ifdef DIVIDER_N_SIGNED_EN
            sq    <= Xin[WIDTH-1] ^ Yin[WIDTH-1];
            sr    <= Xin[WIDTH-1];
`endif
          end
        end
        QC: begin
          if (y_zero) begin
            Quotient  <= '1;
            Remainder <= rz_load;
            DivByZero <= 1'b1;
          end else begin
            r     <= r_nxt;
            q     <= q_nxt[WIDTH-2:0];
            x     <= x << 1;
            count <= count + CNT_W'(1);
            if (last) begin
              Quotient  <= q_load;
              Remainder <= r_load;
              DivByZero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Qi   = state[0];
  assign Qc   = state[1];
  assign Qd   = state[2];
  assign Done = state[2];

endmodule
